// File: rtl/n2t_pc_if.sv
// Command/status bundle between the CPU control decode and the Hack program counter.
interface n2t_pc_if #(parameter int WIDTH = 16);
   logic             clr;
   logic             en;
   logic             load;
   logic             inc;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic             wrap;
   logic             halted;

   modport master (output clr, en, load, inc, in, input out, wrap, halted);
   modport slave  (input clr, en, load, inc, in, output out, wrap, halted);
endinterface

// File: rtl/n2t_pc.sv
// Hack program counter with stall gate, wrap pulse and jump-to-self halt detector.
//
// state | meaning
// RUN   | executing; self_cnt counts consecutive self-jumps
// HALT  | program parked in a jump-to-self loop; halted asserted
module n2t_pc #(
   parameter int WIDTH      = 16,
   parameter int HALT_COUNT = 2
) (
   input  logic     clk,
   input  logic     rst,
   n2t_pc_if.slave  bus
);
   typedef enum logic {RUN, HALT} state_t;

   localparam logic [3:0] HALT_CNT = 4'(HALT_COUNT);

   state_t           state;
   logic [3:0]       self_cnt;
   logic [WIDTH-1:0] pc;
   logic             wrap_q;
   logic             halted_q;
   logic [WIDTH:0]   sum;
   logic             self_jump;
   logic [3:0]       cnt_nxt;

   always_comb begin
      sum       = {1'b0, pc} + {{WIDTH{1'b0}}, 1'b1};
      self_jump = bus.load && (bus.in == pc);
      cnt_nxt   = self_cnt + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= '0;
         wrap_q   <= 1'b0;
         halted_q <= 1'b0;
         self_cnt <= '0;
         state    <= RUN;
      end else if (bus.clr) begin
         pc       <= '0;
         wrap_q   <= 1'b0;
         halted_q <= 1'b0;
         self_cnt <= '0;
         state    <= RUN;
      end else if (!bus.en) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         if (bus.load) begin
            pc <= bus.in;
         end else if (bus.inc) begin
            pc     <= sum[WIDTH-1:0];
            wrap_q <= sum[WIDTH];
         end
         case (state)
            RUN: begin
               if (self_jump) begin
                  if (cnt_nxt >= HALT_CNT) begin
                     self_cnt <= HALT_CNT;
                     state    <= HALT;
                     halted_q <= 1'b1;
                  end else begin
                     self_cnt <= cnt_nxt;
                  end
               end else begin
                  self_cnt <= '0;
               end
            end
            HALT: begin
               // idle cycles and further self-jumps keep the program parked
               if ((bus.load && !self_jump) || (bus.inc && !bus.load)) begin
                  state    <= RUN;
                  halted_q <= 1'b0;
                  self_cnt <= '0;
               end
            end
            default: begin
               state    <= RUN;
               halted_q <= 1'b0;
               self_cnt <= '0;
            end
         endcase
      end
   end

   assign bus.out    = pc;
   assign bus.wrap   = wrap_q;
   assign bus.halted = halted_q;
endmodule

// File: tb/tb_n2t_pc.sv
// Scoreboard bench for n2t_pc: each step queues the expected {out,wrap,halted} and the observed value.
module tb_n2t_pc;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   logic [17:0] sb[$];
   logic [17:0] obs[$];

   n2t_pc_if #(.WIDTH(16)) bus ();

   n2t_pc #(.WIDTH(16), .HALT_COUNT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic c, input logic e, input logic l, input logic i,
                        input logic [15:0] d, input logic [15:0] eo,
                        input logic ew, input logic eh);
      bus.clr  = c;
      bus.en   = e;
      bus.load = l;
      bus.inc  = i;
      bus.in   = d;
      sb.push_back({eo, ew, eh});
      @(posedge clk);
      #1;
      obs.push_back({bus.out, bus.wrap, bus.halted});
   endtask

   task automatic test_reset();
      logic [17:0] exp, got;
      rst = 1'b1;
      bus.clr = 1'b0; bus.en = 1'b1; bus.load = 1'b0; bus.inc = 1'b0; bus.in = '0;
      #12;
      sb.push_back({16'h0000, 1'b0, 1'b0});
      obs.push_back({bus.out, bus.wrap, bus.halted});
      @(negedge clk);
      rst = 1'b0;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL reset: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
      end
   endtask

   task automatic test_inc_load();
      logic [17:0] exp, got;
      int k = 0;
      drive(0, 1, 0, 1, 16'h0000, 16'h0001, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0002, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0003, 0, 0);
      drive(0, 1, 1, 1, 16'h1234, 16'h1234, 0, 0);
      drive(0, 1, 0, 0, 16'h5555, 16'h1234, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL inc_load step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   task automatic test_wrap();
      logic [17:0] exp, got;
      int k = 0;
      drive(0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0001, 0, 0);
      drive(0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
      drive(0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0);
      drive(0, 1, 1, 0, 16'hFFFE, 16'hFFFE, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'hFFFF, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0);
      drive(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0001, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL wrap step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   task automatic test_stall();
      logic [17:0] exp, got;
      int k = 0;
      for (int n = 0; n < 3; n++) drive(0, 0, 1, 1, 16'h0042, 16'h0001, 0, 0);
      drive(1, 0, 1, 1, 16'h0042, 16'h0000, 0, 0);
      drive(0, 1, 1, 0, 16'hFFFF, 16'hFFFF, 0, 0);
      drive(0, 0, 0, 1, 16'h0000, 16'hFFFF, 0, 0);
      drive(1, 1, 1, 1, 16'h0777, 16'h0000, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL stall step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   task automatic test_halt();
      logic [17:0] exp, got;
      int k = 0;
      drive(0, 1, 1, 0, 16'h0010, 16'h0010, 0, 0);
      drive(0, 1, 1, 0, 16'h0010, 16'h0010, 0, 0);
      drive(0, 1, 1, 0, 16'h0010, 16'h0010, 0, 1);
      drive(0, 1, 0, 0, 16'h0000, 16'h0010, 0, 1);
      drive(0, 1, 1, 0, 16'h0010, 16'h0010, 0, 1);
      drive(0, 1, 1, 0, 16'h0020, 16'h0020, 0, 0);
      drive(0, 1, 1, 0, 16'h0020, 16'h0020, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0021, 0, 0);
      drive(0, 1, 1, 0, 16'h0021, 16'h0021, 0, 0);
      drive(0, 1, 1, 0, 16'h0021, 16'h0021, 0, 1);
      drive(0, 1, 0, 1, 16'h0000, 16'h0022, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL halt step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   task automatic test_halt_stall();
      logic [17:0] exp, got;
      int k = 0;
      drive(0, 1, 1, 0, 16'h0022, 16'h0022, 0, 0);
      drive(0, 0, 1, 0, 16'h0022, 16'h0022, 0, 0);
      drive(0, 0, 0, 1, 16'h0000, 16'h0022, 0, 0);
      drive(0, 1, 1, 0, 16'h0022, 16'h0022, 0, 1);
      drive(0, 0, 0, 1, 16'h0000, 16'h0022, 0, 1);
      drive(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      drive(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0001, 0, 0);
      drive(0, 1, 1, 0, 16'h0001, 16'h0001, 0, 0);
      drive(0, 1, 1, 0, 16'h0001, 16'h0001, 0, 1);
      drive(1, 1, 0, 0, 16'h0000, 16'h0000, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL halt_stall step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   task automatic test_async_reset();
      logic [17:0] exp, got;
      int k = 0;
      for (int n = 1; n <= 5; n++) drive(0, 1, 0, 1, 16'h0000, 16'(n), 0, 0);
      drive(0, 1, 1, 0, 16'h0005, 16'h0005, 0, 0);
      drive(0, 1, 1, 0, 16'h0005, 16'h0005, 0, 1);
      bus.load = 1'b0;
      bus.inc  = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      sb.push_back({16'h0000, 1'b0, 1'b0});
      obs.push_back({bus.out, bus.wrap, bus.halted});
      #1;
      rst = 1'b0;
      drive(0, 1, 0, 1, 16'h0000, 16'h0001, 0, 0);
      drive(0, 1, 1, 0, 16'h0001, 16'h0001, 0, 0);
      drive(0, 1, 0, 1, 16'h0000, 16'h0002, 0, 0);
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         got = obs.pop_front();
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL async_reset step %0d: got out=%h wrap=%b halted=%b, want out=%h wrap=%b halted=%b",
                     k, got[17:2], got[1], got[0], exp[17:2], exp[1], exp[0]);
         end
         k++;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_inc_load();
      test_wrap();
      test_stall();
      test_halt();
      test_halt_stall();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
